mod_counter_ctrl: RTL and testbench

//   Programmable modulo-N counter with a run controller.

---
 rtl/mod_counter_ctrl.sv | 142 ++++++++++++++
 tb/tb_mod_counter_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_ctrl.sv
// Programmable modulo-N counter with a start/pause/resume/abort run controller.
// Runs a programmed number of wrap loops and pulses tc per wrap and done at run end.
module mod_counter_ctrl #(
    parameter int WIDTH         = 4,
    parameter int LOOP_W        = 8,
    parameter int DEFAULT_MOD   = 12,
    parameter int DEFAULT_LOOPS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_mod,
    input  logic [LOOP_W-1:0] cfg_loops,
    output logic              cfg_err,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              done,
    output logic              busy,
    output logic [LOOP_W-1:0] loops_left,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mod_reg, mod_d;
    logic [LOOP_W-1:0]  loops_reg, lreg_d;
    logic [WIDTH-1:0]   count_d;
    logic [LOOP_W-1:0]  loops_d;
    logic               tc_d, done_d, cfg_err_d, ready_d, busy_d;
    logic               hs, cfg_ok, wrap, finite;

    assign state  = state_q;
    assign hs     = cfg_valid & cfg_ready;
    assign cfg_ok = cfg_mod >= WIDTH'(2);
    assign wrap   = count == (mod_reg - WIDTH'(1));
    assign finite = loops_reg != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count      <= '0;
            tc         <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_ready  <= 1'b1;
            loops_left <= '0;
            mod_reg    <= WIDTH'(DEFAULT_MOD);
            loops_reg  <= LOOP_W'(DEFAULT_LOOPS);
        end else begin
            state_q    <= state_d;
            count      <= count_d;
            tc         <= tc_d;
            done       <= done_d;
            busy       <= busy_d;
            cfg_err    <= cfg_err_d;
            cfg_ready  <= ready_d;
            loops_left <= loops_d;
            mod_reg    <= mod_d;
            loops_reg  <= lreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count;
        loops_d   = loops_left;
        tc_d      = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        mod_d     = mod_reg;
        lreg_d    = loops_reg;

        // cfg_ready is only high in IDLE, so the modulus is frozen during a run
        if (hs) begin
            if (cfg_ok) begin
                mod_d  = cfg_mod;
                lreg_d = cfg_loops;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && !abort && !pause) begin
                    state_d = RUN;
                    count_d = '0;
                    loops_d = lreg_d;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    loops_d = '0;
                end else if (wrap) begin
                    // A wrap always completes, even when pause arrives on the same edge
                    count_d = '0;
                    tc_d    = 1'b1;
                    if (finite && loops_left == LOOP_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        loops_d = '0;
                    end else begin
                        if (finite) loops_d = loops_left - LOOP_W'(1);
                        if (pause) state_d = PAUSE;
                    end
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    loops_d = '0;
                end else if (start && !pause) begin
                    state_d = RUN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = state_d == IDLE;
        busy_d  = (state_d == RUN) || (state_d == PAUSE);
    end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl; expected values are hand-derived per step.
module tb_mod_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_mod = '0;
    logic [7:0] cfg_loops = '0;
    logic       cfg_err;
    logic       start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [3:0] count;
    logic       tc, done, busy;
    logic [7:0] loops_left;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_counter_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mod(cfg_mod),
        .cfg_loops(cfg_loops), .cfg_err(cfg_err),
        .start(start), .pause(pause), .abort(abort),
        .count(count), .tc(tc), .done(done), .busy(busy),
        .loops_left(loops_left), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 rst = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_loops", loops_left, 0);
        chk("rst_ready", cfg_ready, 1);

        // 1: default modulus 12, free-run
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("t1_state", state, 1);
        chk("t1_count0", count, 0);
        chk("t1_busy", busy, 1);
        for (int i = 1; i <= 24; i++) begin
            step();
            chk("t1_count", count, i % 12);
            chk("t1_tc", tc, (i % 12) == 0);
            chk("t1_done", done, 0);
            chk("t1_loops", loops_left, 0);
        end
        abort = 1'b1; step(); abort = 1'b0;
        chk("t1_abort_state", state, 0);

        // 2: mod 5, three loops
        cfg_valid = 1'b1; cfg_mod = 4'd5; cfg_loops = 8'd3;
        step(); cfg_valid = 1'b0;
        chk("t2_cfg_err", cfg_err, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("t2_loops_init", loops_left, 3);
        chk("t2_count0", count, 0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t2_count", count, i % 5);
            chk("t2_tc", tc, (i % 5) == 0);
            chk("t2_loops", loops_left, 3 - i / 5);
            chk("t2_state", state, (i == 15) ? 3 : 1);
            chk("t2_done", done, i == 15);
        end
        step();
        chk("t2_idle", state, 0);
        chk("t2_done_clr", done, 0);
        chk("t2_tc_clr", tc, 0);
        chk("t2_ready", cfg_ready, 1);

        // 3: pause at count 7, hold, resume
        cfg_valid = 1'b1; cfg_mod = 4'd12; cfg_loops = 8'd0;
        step(); cfg_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t3_pre_pause", count, 7);
        pause = 1'b1; step(); pause = 1'b0;
        chk("t3_pause_state", state, 2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_count", count, 7);
            chk("t3_hold_busy", busy, 1);
            chk("t3_hold_state", state, 2);
            chk("t3_hold_tc", tc, 0);
        end
        start = 1'b1; step(); start = 1'b0;
        chk("t3_resume_state", state, 1);
        chk("t3_resume_count", count, 7);
        step(); chk("t3_count8", count, 8);
        step(); chk("t3_count9", count, 9);
        chk("t3_busy", busy, 1);
        abort = 1'b1; step(); abort = 1'b0;

        // 4: abort mid-run, mod 6 loops 4
        cfg_valid = 1'b1; cfg_mod = 4'd6; cfg_loops = 8'd4;
        step(); cfg_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("t4_pre_count", count, 3);
        chk("t4_pre_loops", loops_left, 2);
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4_state", state, 0);
        chk("t4_count", count, 0);
        chk("t4_loops", loops_left, 0);
        chk("t4_tc", tc, 0);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        step();
        chk("t4_tc_after", tc, 0);
        chk("t4_done_after", done, 0);

        // 5: rejected config, then config attempt during a run
        cfg_valid = 1'b1; cfg_mod = 4'd1; cfg_loops = 8'd2;
        step(); cfg_valid = 1'b0;
        chk("t5_cfg_err", cfg_err, 1);
        step();
        chk("t5_cfg_err_clr", cfg_err, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("t5_ready_run", cfg_ready, 0);
        chk("t5_loops", loops_left, 4);
        cfg_valid = 1'b1; cfg_mod = 4'd3; cfg_loops = 8'd1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("t5_count", count, i % 6);
            chk("t5_tc", tc, i == 6);
            chk("t5_cfg_err_run", cfg_err, 0);
        end
        cfg_valid = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t5_mod_kept", count, 0);
        chk("t5_mod_kept_tc", tc, 1);
        abort = 1'b1; step(); abort = 1'b0;

        // 6: async reset mid-run, modulus back to default
        cfg_valid = 1'b1; cfg_mod = 4'd11; cfg_loops = 8'd0;
        step(); cfg_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("t6_pre_count", count, 9);
        #2 rst = 1'b1;
        #1;
        chk("t6_count", count, 0);
        chk("t6_state", state, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", cfg_ready, 1);
        #1 rst = 1'b0;
        step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("t6_count11", count, 11);
        step();
        chk("t6_wrap", count, 0);
        chk("t6_wrap_tc", tc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
